// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides.
// Shifts run one bit per cycle; every other opcode finishes in a single EXEC cycle.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    PASS_INPUTA    = 4'd0,
    SHIFT_LEFT     = 4'd1,
    SHIFT_RIGHT    = 4'd2,
    KEEP_SMALLER   = 4'd3,
    SHIFT_ON       = 4'd4,
    ADD            = 4'd5,
    INPUTA_IS_ZERO = 4'd6,
    PASS_INPUTB    = 4'd7,
    INC_INPUTA     = 4'd8,
    DEC_INPUTA     = 4'd9,
    CLEAR          = 4'd10,
    SUB            = 4'd11,
    PARALLEL       = 4'd12
  } opcodeT;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} stateT;

  stateT            state;
  logic [3:0]       opReg;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [SHW-1:0]   cnt;

  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   subDiff;
  logic [WIDTH:0]   incSum;
  logic [WIDTH:0]   decDiff;
  logic [WIDTH-1:0] shiftStep;
  logic [WIDTH-1:0] popCount;
  logic             isShift;
  logic [WIDTH-1:0] nextResult;
  logic             nextCarry;
  logic             nextIllegal;

  // The top bit of each widened sum/difference is the carry-out or borrow.
  assign addSum  = {1'b0, aReg} + {1'b0, bReg};
  assign subDiff = {1'b0, aReg} - {1'b0, bReg};
  assign incSum  = {1'b0, aReg} + {{WIDTH{1'b0}}, 1'b1};
  assign decDiff = {1'b0, aReg} - {{WIDTH{1'b0}}, 1'b1};

  assign isShift   = (opReg == SHIFT_LEFT) || (opReg == SHIFT_RIGHT);
  assign shiftStep = (opReg == SHIFT_LEFT) ? (aReg << 1) : (aReg >> 1);
  assign in_ready  = (state == IDLE);

  always_comb begin
    popCount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popCount = popCount + WIDTH'(aReg[i]);
    end
  end

  // aReg doubles as the shift accumulator, so shift results come from the final step.
  always_comb begin
    nextResult  = '0;
    nextCarry   = 1'b0;
    nextIllegal = 1'b0;
    case (opReg)
      PASS_INPUTA:    nextResult = aReg;
      SHIFT_LEFT,
      SHIFT_RIGHT:    nextResult = (cnt == '0) ? aReg : shiftStep;
      KEEP_SMALLER:   nextResult = (aReg < bReg) ? aReg : bReg;
      SHIFT_ON:       nextResult = (aReg << 1) | {{(WIDTH-1){1'b0}}, 1'b1};
      ADD:            {nextCarry, nextResult} = addSum;
      INPUTA_IS_ZERO: nextResult = {{(WIDTH-1){1'b0}}, (aReg == '0)};
      PASS_INPUTB:    nextResult = bReg;
      INC_INPUTA:     {nextCarry, nextResult} = incSum;
      DEC_INPUTA:     {nextCarry, nextResult} = decDiff;
      CLEAR:          nextResult = '0;
      SUB:            {nextCarry, nextResult} = subDiff;
      PARALLEL:       nextResult = popCount;
      default:        nextIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      opReg     <= '0;
      aReg      <= '0;
      bReg      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opReg <= op;
            aReg  <= a;
            bReg  <= b;
            cnt   <= b[SHW-1:0];
            state <= EXEC;
          end
        end
        EXEC: begin
          // Keep stepping while more than one shift remains; the last one lands in result.
          if (isShift && (cnt > SHW'(1))) begin
            aReg <= shiftStep;
            cnt  <= cnt - SHW'(1);
          end else begin
            result    <= nextResult;
            carry     <= nextCarry;
            zero      <= (nextResult == '0);
            illegal   <= nextIllegal;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH = 8 with hand-computed expectations.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       illegal;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expResult;
    logic       expCarry;
    logic       expIllegal;
    int         expCycles;
  } vectorT;

  vectorT vecs[11];

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one request for exactly the accepting edge.
  task automatic applyStimulus(input logic [3:0] opIn, input logic [7:0] aIn, input logic [7:0] bIn);
    in_valid = 1'b1;
    op       = opIn;
    a        = aIn;
    b        = bIn;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!out_valid && cycles < 50);
  endtask

  task automatic ackResult(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, ".validAfterAck"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".readyAfterAck"}, 32'(in_ready), 32'd1);
  endtask

  task automatic runVector(input string tag, input vectorT v);
    int cycles;
    applyStimulus(v.op, v.a, v.b);
    waitResult(cycles);
    checkOutput({tag, ".cycles"}, 32'(cycles), 32'(v.expCycles));
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ".result"}, 32'(result), 32'(v.expResult));
    checkOutput({tag, ".carry"}, 32'(carry), 32'(v.expCarry));
    checkOutput({tag, ".zero"}, 32'(zero), 32'(v.expResult == 8'h00));
    checkOutput({tag, ".illegal"}, 32'(illegal), 32'(v.expIllegal));
    ackResult(tag);
  endtask

  initial begin
    int cycles;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 4'd0;
    a         = 8'h00;
    b         = 8'h00;

    vecs[0]  = '{4'd0,  8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'd4,  8'h40, 8'h00, 8'h81, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'd6,  8'h00, 8'h33, 8'h01, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'd7,  8'h11, 8'hA5, 8'hA5, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'd10, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'd8,  8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1};
    vecs[6]  = '{4'd1,  8'h01, 8'h0F, 8'h80, 1'b0, 1'b0, 7};
    vecs[7]  = '{4'd2,  8'h80, 8'h01, 8'h40, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'd15, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1};
    vecs[9]  = '{4'd5,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1};
    vecs[10] = '{4'd11, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1};

    #1;
    checkOutput("reset.inReady", 32'(in_ready), 32'd1);
    checkOutput("reset.outValid", 32'(out_valid), 32'd0);
    checkOutput("reset.result", 32'(result), 32'd0);
    checkOutput("reset.flags", {29'd0, carry, zero, illegal}, 32'd0);
    #13;
    reset = 1'b0;
    tick();

    // ADD with the consumer already ready: one-cycle result, then back to IDLE.
    out_ready = 1'b1;
    applyStimulus(4'd5, 8'hF0, 8'h20);
    checkOutput("add.readyInExec", 32'(in_ready), 32'd0);
    tick();
    checkOutput("add.valid", 32'(out_valid), 32'd1);
    checkOutput("add.result", 32'(result), 32'h10);
    checkOutput("add.carry", 32'(carry), 32'd1);
    checkOutput("add.zero", 32'(zero), 32'd0);
    tick();
    out_ready = 1'b0;
    checkOutput("add.validOneCycle", 32'(out_valid), 32'd0);
    checkOutput("add.readyNext", 32'(in_ready), 32'd1);

    // SUB to zero, held while the consumer stalls.
    applyStimulus(4'd11, 8'h05, 8'h05);
    waitResult(cycles);
    checkOutput("sub.cycles", 32'(cycles), 32'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("sub.holdValid", 32'(out_valid), 32'd1);
      checkOutput("sub.holdResult", {21'd0, result, carry, zero, illegal}, {21'd0, 8'h00, 1'b0, 1'b1, 1'b0});
      tick();
    end
    ackResult("sub");

    runVector("dec", '{4'd9, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1});
    runVector("shl3", '{4'd1, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 3});
    runVector("shr0", '{4'd2, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1});

    // A different request held during a shift is neither taken nor queued.
    applyStimulus(4'd2, 8'hF0, 8'h04);
    in_valid = 1'b1;
    op       = 4'd5;
    a        = 8'h01;
    b        = 8'h01;
    checkOutput("ignore.readyInExec", 32'(in_ready), 32'd0);
    waitResult(cycles);
    checkOutput("ignore.cycles", 32'(cycles), 32'd4);
    checkOutput("ignore.result", 32'(result), 32'h0F);
    in_valid = 1'b0;
    ackResult("ignore");
    tick();
    checkOutput("ignore.noQueue", 32'(out_valid), 32'd0);

    runVector("min", '{4'd3, 8'h7F, 8'h80, 8'h7F, 1'b0, 1'b0, 1});
    runVector("illegal13", '{4'd13, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1, 1});
    runVector("popcount", '{4'd12, 8'hB5, 8'h00, 8'h05, 1'b0, 1'b0, 1});

    for (int i = 0; i < 11; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset two cycles into a long shift aborts it without a clock edge.
    applyStimulus(4'd2, 8'hFF, 8'h07);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort.outValid", 32'(out_valid), 32'd0);
    checkOutput("abort.inReady", 32'(in_ready), 32'd1);
    checkOutput("abort.result", 32'(result), 32'd0);
    #1;
    reset = 1'b0;
    cycles = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) cycles++;
    end
    checkOutput("abort.noResult", 32'(cycles), 32'd0);
    runVector("postReset", '{4'd5, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal >= 4, power of two).
REQ-002 SHALL have localparam SHW = log2(WIDTH), width of the shift-amount field.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port op  input  4  opcode, using the team's 4-bit ALU instruction map.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  WIDTH  operation result.
REQ-013 SHALL have port carry  output  1  carry-out/borrow flag.
REQ-014 SHALL have port zero  output  1  result == 0.
REQ-015 SHALL have port illegal  output  1  opcode 13..15 was issued.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-017 Accept SHALL occur when in_valid && in_ready; op, a, b latched, FSM -> EXEC; inputs ignored otherwise.
REQ-018 Opcode results, mod 2^WIDTH:
- 0 PASS_INPUTA = a.
- 1 SHIFT_LEFT = a << b[SHW-1:0], zero fill.
- 2 SHIFT_RIGHT = a >> b[SHW-1:0], logical.
- 3 KEEP_SMALLER = unsigned min(a, b).
- 4 SHIFT_ON = (a << 1) | 1.
- 5 ADD = a + b.
- 6 INPUTA_IS_ZERO = (a == 0) zero-extended.
- 7 PASS_INPUTB = b.
- 8 INC_INPUTA = a + 1.
- 9 DEC_INPUTA = a - 1.
- 10 CLEAR = 0.
- 11 SUB = a - b.
- 12 PARALLEL = popcount(a).
REQ-019 carry SHALL be: ADD/INC carry-out; SUB/DEC borrow (1 when subtrahend > minuend, unsigned); 0 for all other ops.
REQ-020 Opcodes 13..15 SHALL produce result = 0, carry = 0, zero = 1, illegal = 1; all legal ops SHALL give illegal = 0.
REQ-021 Non-shift ops SHALL spend exactly 1 cycle in EXEC: accept at edge t, out_valid = 1 after edge t+1.
REQ-022 SHIFT_LEFT/RIGHT SHALL be iterative, 1 bit per cycle, with an internal down-counter loaded with k = b[SHW-1:0].
- EXEC lasts max(k, 1) cycles; out_valid after edge t+max(k,1).
- k = 0 returns a unchanged in 1 cycle.
REQ-023 In DONE: out_valid = 1; result/carry/zero/illegal held stable until out_ready = 1.
REQ-024 Edge with out_valid && out_ready SHALL move FSM -> IDLE; in_ready = 1 the following cycle (no back-to-back overlap).
REQ-025 Outside DONE: out_valid = 0; result/flags hold the last delivered value.
REQ-026 out_ready asserted while not in DONE SHALL have no effect.
REQ-027 in_valid asserted while not in IDLE SHALL have no effect, and the request SHALL not be queued.

Reset
REQ-028 reset = 1 SHALL immediately, independent of clk, force:
- FSM = IDLE, shift counter = 0.
- in_ready = 1, out_valid = 0.
- result = 0, carry = 0, zero = 0, illegal = 0.
REQ-029 Reset mid-EXEC or mid-DONE SHALL abort the operation with no result delivered; the first accept after reset release SHALL behave as from power-up.

Verification (WIDTH = 8)
REQ-030 ADD a = 0xF0, b = 0x20, out_ready = 1 -> 1 cycle later: result = 0x10, carry = 1, zero = 0, out_valid for 1 cycle, in_ready = 1 next cycle.
REQ-031 SUB a = 0x05, b = 0x05, out_ready = 0 for 3 cycles -> result = 0x00, zero = 1, carry = 0, held stable 3 cycles; DEC a = 0x00 -> result = 0xFF, carry = 1.
REQ-032 SHIFT_LEFT a = 0x81, b = 0x03 -> out_valid exactly 3 cycles after accept, result = 0x08; SHIFT_RIGHT b = 0x00 -> result = a after 1 cycle.
REQ-033 in_valid held high during an EXEC shift with a different op -> ignored; only the first result is returned. KEEP_SMALLER 0x7F, 0x80 -> result = 0x7F.
REQ-034 op = 13 -> result = 0, zero = 1, illegal = 1; PARALLEL a = 0xB5 -> result = 0x05.
REQ-035 reset asserted 2 cycles into SHIFT_RIGHT b = 7 -> out_valid = 0 and in_ready = 1 with no clock edge; no result ever appears; next ADD 1 + 1 returns 0x02.
